// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator and its adder.
package product_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

    localparam int PROD_W_DEF = 8;
    localparam int LEN_W_DEF  = 4;
    localparam int ACC_W_DEF  = 12;

    // Largest product a 4x4 unsigned multiplier can deliver (15*15).
    localparam int MAX_PROD = 225;

endpackage

// File: rtl/product_accumulator_acc_sat_adder.sv
// Accumulator adder: sum computed one bit wider than the accumulator so the
// carry flags overflow; optionally clamps the result to all-ones.
module acc_sat_adder #(
    parameter int ACC_W    = 12,
    parameter int PROD_W   = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod_in,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] sum_full;

    always_comb begin
        sum_full = {1'b0, acc_in} + (ACC_W + 1)'(prod_in);
        carry    = sum_full[ACC_W];
        if (carry && SATURATE) begin
            sum = '1;
        end else begin
            sum = sum_full[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Dot-product accumulator downstream of the 4x4 multiplier: sums a programmed
// number of products and hands the result out over a valid/ready handshake.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W   = PROD_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              overflow
);

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              overflow_q, overflow_d;

    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;

    acc_sat_adder #(
        .ACC_W    (ACC_W),
        .PROD_W   (PROD_W),
        .SATURATE (SATURATE)
    ) u_adder (
        .acc_in  (acc_q),
        .prod_in (prod_in),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        len_d      = len_q;
        overflow_d = overflow_q;

        // abort wins over start and over any product offered this cycle
        if (abort) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_d      = len;
                        acc_d      = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        state_d    = (len != '0) ? ST_ACCUM : ST_DONE;
                    end
                end
                ST_ACCUM: begin
                    if (prod_valid) begin
                        acc_d   = add_sum;
                        count_d = count_q + LEN_W'(1);
                        if (add_carry) begin
                            overflow_d = 1'b1;
                        end
                        if (count_q == len_q - LEN_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (acc_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign prod_ready = (state_q == ST_ACCUM);
    assign acc_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign acc_out    = acc_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized bench for product_accumulator: three instances (12-bit saturating,
// 10-bit saturating, 10-bit wrapping) share stimulus and are checked per job.
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  len;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        acc_ready;

    logic        prod_ready, acc_valid, busy, ovf12;
    logic [11:0] acc12;
    logic        prod_ready_s, acc_valid_s, busy_s, ovf10s;
    logic [9:0]  acc10s;
    logic        prod_ready_w, acc_valid_w, busy_w, ovf10w;
    logic [9:0]  acc10w;

    int total = 0;
    int bad   = 0;

    int prods[$];

    product_accumulator #(.PROD_W(8), .LEN_W(4), .ACC_W(12), .SATURATE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .acc_out(acc12), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .overflow(ovf12)
    );

    product_accumulator #(.PROD_W(8), .LEN_W(4), .ACC_W(10), .SATURATE(1'b1)) u_sat10 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready_s),
        .acc_out(acc10s), .acc_valid(acc_valid_s), .acc_ready(acc_ready),
        .busy(busy_s), .overflow(ovf10s)
    );

    product_accumulator #(.PROD_W(8), .LEN_W(4), .ACC_W(10), .SATURATE(1'b0)) u_wrap10 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready_w),
        .acc_out(acc10w), .acc_valid(acc_valid_w), .acc_ready(acc_ready),
        .busy(busy_w), .overflow(ovf10w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: add products in order; a sum reaching 2**w is an overflow,
    // after which the value is clamped or reduced modulo 2**w.
    function automatic void model(input int w, input bit sat, output int res, output int ovf);
        int lim;
        lim = 1 << w;
        res = 0;
        ovf = 0;
        foreach (prods[i]) begin
            res += prods[i];
            if (res >= lim) begin
                ovf = 1;
                res = sat ? lim - 1 : res - lim;
            end
        end
    endfunction

    task automatic chk_all_idle_zero(input string tag);
        chk_eq({tag, "_busy"}, busy | busy_s | busy_w, 0);
        chk_eq({tag, "_prod_ready"}, prod_ready | prod_ready_s | prod_ready_w, 0);
        chk_eq({tag, "_acc_valid"}, acc_valid | acc_valid_s | acc_valid_w, 0);
        chk_eq({tag, "_acc12"}, acc12, 0);
        chk_eq({tag, "_acc10s"}, acc10s, 0);
        chk_eq({tag, "_acc10w"}, acc10w, 0);
        chk_eq({tag, "_ovf"}, ovf12 | ovf10s | ovf10w, 0);
    endtask

    task automatic chk_results(input string tag);
        int e12, o12, es, os, ew, ow;
        model(12, 1'b1, e12, o12);
        model(10, 1'b1, es, os);
        model(10, 1'b0, ew, ow);
        chk_eq({tag, "_acc12"}, acc12, e12);
        chk_eq({tag, "_ovf12"}, ovf12, o12);
        chk_eq({tag, "_acc10s"}, acc10s, es);
        chk_eq({tag, "_ovf10s"}, ovf10s, os);
        chk_eq({tag, "_acc10w"}, acc10w, ew);
        chk_eq({tag, "_ovf10w"}, ovf10w, ow);
    endtask

    // Entered and left at posedge+1 with the block idle. mode: 0 = valid
    // held high, 1 = valid toggles 1/0, 2 = random gaps.
    task automatic run_job(input string tag, input int mode, input int ready_delay);
        int n, sent, cyc, e12, o12;
        bit v;
        n = prods.size();
        model(12, 1'b1, e12, o12);
        start = 1'b1;
        len   = 4'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk_eq({tag, "_busy"}, busy, 1);
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 64) begin
            chk_eq({tag, "_prod_ready"}, prod_ready, 1);
            chk_eq({tag, "_acc_valid_early"}, acc_valid, 0);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            prod_valid = v;
            prod_in    = v ? 8'(prods[sent]) : 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            if (v) sent++;
            cyc++;
        end
        prod_valid = 1'b0;
        if (sent < n) chk_eq({tag, "_timeout"}, sent, n);
        chk_eq({tag, "_acc_valid_lat"}, acc_valid & acc_valid_s & acc_valid_w, 1);
        chk_eq({tag, "_prod_ready_done"}, prod_ready | prod_ready_s | prod_ready_w, 0);
        chk_results(tag);
        for (int i = 0; i < ready_delay; i++) begin
            if (i == 0) begin
                start = 1'b1;
                len   = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk_eq({tag, "_hold_valid"}, acc_valid, 1);
            chk_eq({tag, "_hold_acc"}, acc12, e12);
        end
        acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        chk_eq({tag, "_valid_drop"}, acc_valid | acc_valid_s | acc_valid_w, 0);
        chk_eq({tag, "_idle"}, busy, 0);
        chk_results({tag, "_idle"});
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        len        = '0;
        prod_in    = '0;
        prod_valid = 1'b0;
        acc_ready  = 1'b0;
        #12;
        chk_all_idle_zero("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;

        prods = '{15, 225, 100};
        run_job("len3", 0, 0);

        prods = '{225, 225, 225, 225};
        run_job("len4_toggle", 1, 5);

        prods = {};
        run_job("len0", 0, 2);

        prods = '{225, 225, 225, 225, 225};
        run_job("len5_ovf", 0, 1);

        // abort mid-job with start and a product offered in the same cycle
        start = 1'b1;
        len   = 4'd4;
        @(posedge clk); #1;
        start      = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 8'd50;
        @(posedge clk); #1;
        prod_in = 8'd60;
        @(posedge clk); #1;
        prod_in = 8'd70;
        abort   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        abort      = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        chk_all_idle_zero("abort");
        abort = 1'b1;
        start = 1'b1;
        len   = 4'd3;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        chk_eq("abort_idle_start_busy", busy, 0);

        prods = '{7};
        run_job("after_abort", 0, 0);

        // asynchronous reset between clock edges in the middle of a job
        start = 1'b1;
        len   = 4'd6;
        @(posedge clk); #1;
        start      = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 8'd200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all_idle_zero("async_rst");
        #2;
        rst        = 1'b0;
        prod_valid = 1'b0;
        @(posedge clk); #1;
        chk_eq("after_rst_busy", busy, 0);

        for (int j = 0; j < 12; j++) begin
            int n;
            n = $urandom_range(0, 15);
            prods = {};
            for (int k = 0; k < n; k++) begin
                prods.push_back($urandom_range(0, 15) * $urandom_range(0, 15));
            end
            run_job($sformatf("rand%0d", j), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
